hazard_stall_ctrl: RTL and testbench

//  Hazard/stall controller for the 5-stage pipeline. Drives Stall into the F-stage PC and D-stage pipe registers.

---
 rtl/hazard_stall_ctrl_if.sv | 34 +++
 rtl/hazard_stall_ctrl.sv | 66 ++++++
 tb/tb_hazard_stall_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// rtl/hazard_stall_ctrl_if.sv - pipeline-to-hazard-controller signal bundle
interface hazard_stall_ctrl_if;
   logic [4:0]  rs_D;
   logic [4:0]  rt_D;
   logic [1:0]  tuse_rs_D;
   logic [1:0]  tuse_rt_D;
   logic [4:0]  wa_E;
   logic [1:0]  tnew_E;
   logic [4:0]  wa_M;
   logic [1:0]  tnew_M;
   logic        md_start_E;
   logic        md_div_E;
   logic        md_use_D;
   logic        Stall;
   logic        Flush_E;
   logic        md_busy;
   logic [31:0] stall_cnt;

   // pipeline side: presents D/E/M stage info, consumes stall controls
   modport master (
      output rs_D, rt_D, tuse_rs_D, tuse_rt_D,
      output wa_E, tnew_E, wa_M, tnew_M,
      output md_start_E, md_div_E, md_use_D,
      input  Stall, Flush_E, md_busy, stall_cnt
   );

   // controller side
   modport slave (
      input  rs_D, rt_D, tuse_rs_D, tuse_rt_D,
      input  wa_E, tnew_E, wa_M, tnew_M,
      input  md_start_E, md_div_E, md_use_D,
      output Stall, Flush_E, md_busy, stall_cnt
   );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - RAW/mult-div stall controller, optional STALL_PERF_EN stall counter
module hazard_stall_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10,
   parameter int CNT_W    = 4
) (
   input logic               clk,
   input logic               reset,
   hazard_stall_ctrl_if.slave hz
);

   logic [CNT_W-1:0] busy_cnt;
   logic             stall_rs;
   logic             stall_rt;
   logic             stall_md;
   logic             stall;

   // RAW hazards that forwarding cannot resolve; $0 is hardwired and never waits
   always_comb begin
      stall_rs = (hz.rs_D != 5'd0) &&
                 (((hz.rs_D == hz.wa_E) && (hz.tnew_E > hz.tuse_rs_D)) ||
                  ((hz.rs_D == hz.wa_M) && (hz.tnew_M > hz.tuse_rs_D)));
      stall_rt = (hz.rt_D != 5'd0) &&
                 (((hz.rt_D == hz.wa_E) && (hz.tnew_E > hz.tuse_rt_D)) ||
                  ((hz.rt_D == hz.wa_M) && (hz.tnew_M > hz.tuse_rt_D)));
   end

   // mult/div users wait while the unit is running or is being started right now
   always_comb begin
      stall_md = hz.md_use_D && ((busy_cnt != '0) || hz.md_start_E);
      stall    = stall_rs | stall_rt | stall_md;
   end

   assign hz.Stall   = stall;
   assign hz.Flush_E = stall;
   assign hz.md_busy = (busy_cnt != '0);

   // busy down-counter: load on an accepted start, otherwise run down to zero and stop
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_cnt <= '0;
      end else if (hz.md_start_E && (busy_cnt == '0)) begin
         busy_cnt <= hz.md_div_E ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
      end else if (busy_cnt != '0) begin
         busy_cnt <= busy_cnt - CNT_W'(1);
      end
   end

`ifdef STALL_PERF_EN
   logic [31:0] perf_cnt;

   // counts every cycle the front end is held; wraps naturally at 32 bits
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_cnt <= 32'd0;
      end else if (stall) begin
         perf_cnt <= perf_cnt + 32'd1;
      end
   end

   assign hz.stall_cnt = perf_cnt;
`else
   assign hz.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - randomized and directed bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;

   localparam int MULT_CYC = 5;
   localparam int DIV_CYC  = 10;

   logic clk;
   logic reset;

   hazard_stall_ctrl_if hz ();

   hazard_stall_ctrl #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC),
      .CNT_W    (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          chk_cnt  = 0;
   int          pass_cnt = 0;
   int          cyc      = 0;   // index of the cycle between two rising edges
   int          busy_last = -1; // last cycle index during which the unit is busy
   logic [31:0] perf_exp = 32'd0;
   int          stall_seen;
   int          busy_seen;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs === exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic bit raw_hit(input logic [4:0] src, input logic [1:0] tuse);
      bit hit;
      hit = 1'b0;
      if (src != 5'd0) begin
         if (src == hz.wa_E && int'(hz.tnew_E) > int'(tuse)) hit = 1'b1;
         if (src == hz.wa_M && int'(hz.tnew_M) > int'(tuse)) hit = 1'b1;
      end
      return hit;
   endfunction

   function automatic bit model_busy();
      return reset && (cyc <= busy_last);
   endfunction

   function automatic bit model_stall();
      bit md;
      md = hz.md_use_D && (model_busy() || hz.md_start_E);
      return raw_hit(hz.rs_D, hz.tuse_rs_D) || raw_hit(hz.rt_D, hz.tuse_rt_D) || md;
   endfunction

   task automatic clr_in();
      hz.rs_D = 0; hz.rt_D = 0; hz.tuse_rs_D = 2'd3; hz.tuse_rt_D = 2'd3;
      hz.wa_E = 0; hz.tnew_E = 0; hz.wa_M = 0; hz.tnew_M = 0;
      hz.md_start_E = 0; hz.md_div_E = 0; hz.md_use_D = 0;
   endtask

   // check the current cycle against the model, then advance across one rising edge
   task automatic run_cycle(input string tag);
      bit exp_s;
      #1;
      exp_s = model_stall();
      check_val({tag, "_stall"}, 32'(hz.Stall), 32'(exp_s));
      check_val({tag, "_flush"}, 32'(hz.Flush_E), 32'(exp_s));
      check_val({tag, "_busy"}, 32'(hz.md_busy), 32'(model_busy()));
      check_val({tag, "_cnt"}, hz.stall_cnt, perf_exp);
      if (hz.Stall) stall_seen++;
      if (hz.md_busy) busy_seen++;
      @(posedge clk);
      if (reset) begin
         if (hz.md_start_E && !(cyc <= busy_last))
            busy_last = cyc + (hz.md_div_E ? DIV_CYC : MULT_CYC);
`ifdef STALL_PERF_EN
         if (exp_s) perf_exp = perf_exp + 32'd1;
`endif
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      busy_last = -1;
      perf_exp = 32'd0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0;
      clr_in();
      @(negedge clk);
      #1;
      check_val("rst_busy", 32'(hz.md_busy), 32'd0);
      check_val("rst_cnt", hz.stall_cnt, 32'd0);
      check_val("rst_stall", 32'(hz.Stall), 32'd0);
      do_reset();

      // 1: load-use stalls, then resolves once producer reaches M
      clr_in();
      hz.wa_E = 5'd8; hz.tnew_E = 2'd2; hz.rs_D = 5'd8; hz.tuse_rs_D = 2'd1;
      #1 check_val("t1_stall", 32'(hz.Stall), 32'd1);
      check_val("t1_flush", 32'(hz.Flush_E), 32'd1);
      run_cycle("t1a");
      hz.wa_E = 5'd0; hz.tnew_E = 2'd0; hz.wa_M = 5'd8; hz.tnew_M = 2'd1;
      #1 check_val("t1_clear", 32'(hz.Stall), 32'd0);
      run_cycle("t1b");

      // 2: register $0 never stalls
      clr_in();
      hz.rs_D = 0; hz.wa_E = 0; hz.tnew_E = 2'd2; hz.tuse_rs_D = 2'd0;
      #1 check_val("t2_zero", 32'(hz.Stall), 32'd0);
      run_cycle("t2");

      // 3: mult then mfhi held; stall count starts from a fresh reset
      clr_in();
      do_reset();
      stall_seen = 0; busy_seen = 0;
      hz.md_start_E = 1'b1; hz.md_div_E = 1'b0; hz.md_use_D = 1'b1;
      run_cycle("t3s");
      hz.md_start_E = 1'b0;
      for (int i = 0; i < 7; i++) run_cycle("t3");
      check_val("t3_nstall", 32'(stall_seen), 32'd6);
      check_val("t3_nbusy", 32'(busy_seen), 32'd5);
      #1 check_val("t3_after", 32'(hz.Stall), 32'd0);
`ifdef STALL_PERF_EN
      check_val("t6_perf", hz.stall_cnt, 32'd6);
`else
      check_val("t6_perf", hz.stall_cnt, 32'd0);
`endif

      // 4: div then mflo held; a non-MD D instr mid-busy does not stall
      clr_in();
      stall_seen = 0; busy_seen = 0;
      hz.md_start_E = 1'b1; hz.md_div_E = 1'b1; hz.md_use_D = 1'b1;
      run_cycle("t4s");
      hz.md_start_E = 1'b0; hz.md_div_E = 1'b0;
      for (int i = 0; i < 11; i++) run_cycle("t4");
      check_val("t4_nstall", 32'(stall_seen), 32'd11);
      check_val("t4_nbusy", 32'(busy_seen), 32'd10);
      hz.md_start_E = 1'b1; hz.md_div_E = 1'b1;
      run_cycle("t4s2");
      hz.md_start_E = 1'b0; hz.md_use_D = 1'b0;
      run_cycle("t4b");
      #1 check_val("t4_nonmd_busy", 32'(hz.md_busy), 32'd1);
      check_val("t4_nonmd_stall", 32'(hz.Stall), 32'd0);
      for (int i = 0; i < 10; i++) run_cycle("t4d");

      // 5: reset mid-div clears busy with no clock edge, next mult reloads
      clr_in();
      hz.md_start_E = 1'b1; hz.md_div_E = 1'b1;
      run_cycle("t5s");
      hz.md_start_E = 1'b0; hz.md_div_E = 1'b0;
      for (int i = 0; i < 3; i++) run_cycle("t5");
      #2 reset = 1'b0;
      busy_last = -1; perf_exp = 32'd0;
      #1 check_val("t5_async_busy", 32'(hz.md_busy), 32'd0);
      check_val("t5_async_cnt", hz.stall_cnt, 32'd0);
      @(posedge clk); cyc++;
      @(negedge clk); reset = 1'b1;
      busy_seen = 0;
      hz.md_start_E = 1'b1;
      run_cycle("t5m");
      hz.md_start_E = 1'b0;
      for (int i = 0; i < 7; i++) run_cycle("t5r");
      check_val("t5_nbusy", 32'(busy_seen), 32'd5);

      // randomized traffic over a small register window to provoke hits
      for (int i = 0; i < 400; i++) begin
         hz.rs_D = 5'($urandom_range(0, 3));
         hz.rt_D = 5'($urandom_range(0, 3));
         hz.tuse_rs_D = 2'($urandom_range(0, 3));
         hz.tuse_rt_D = 2'($urandom_range(0, 3));
         hz.wa_E = 5'($urandom_range(0, 3));
         hz.tnew_E = 2'($urandom_range(0, 3));
         hz.wa_M = 5'($urandom_range(0, 3));
         hz.tnew_M = 2'($urandom_range(0, 3));
         hz.md_start_E = ($urandom_range(0, 7) == 0);
         hz.md_div_E = 1'($urandom_range(0, 1));
         hz.md_use_D = 1'($urandom_range(0, 1));
         run_cycle("rnd");
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
